// File: rtl/gb80_fetch_unit_if.sv
// Fetch unit port bundle: memory request/ack, decoder handshake, redirect/stall control.
// master = fetch unit side, slave = memory/decoder/sequencer side.
// No storage; backpressure is carried by i_mem_ack and i_instr_ready.
interface gb80_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 4
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic                  o_mem_req;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  i_mem_ack;
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic                  o_instr_valid;
    logic [DATA_WIDTH-1:0] o_instr_data;
    logic [ADDR_WIDTH-1:0] o_instr_addr;
    logic                  i_instr_ready;
    logic                  i_redirect;
    logic [ADDR_WIDTH-1:0] i_redirect_addr;
    logic                  i_stall;
    logic [ADDR_WIDTH-1:0] o_fetch_pc;
    logic [CW-1:0]         o_queue_count;

    modport master (
        output o_mem_req, o_mem_addr,
        input  i_mem_ack, i_mem_data,
        output o_instr_valid, o_instr_data, o_instr_addr,
        input  i_instr_ready, i_redirect, i_redirect_addr, i_stall,
        output o_fetch_pc, o_queue_count
    );

    modport slave (
        input  o_mem_req, o_mem_addr,
        output i_mem_ack, i_mem_data,
        input  o_instr_valid, o_instr_data, o_instr_addr,
        output i_instr_ready, i_redirect, i_redirect_addr, i_stall,
        input  o_fetch_pc, o_queue_count
    );
endinterface

// File: rtl/gb80_fetch_unit.sv
// Instruction fetch: owned PC, wait-state tolerant memory handshake, prefetch queue.
// Latency: ack -> o_instr_valid 1 cycle; back-to-back requests give 1 byte/cycle.
// Backpressure: no new request unless queue count plus outstanding stays within depth.
module gb80_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    QUEUE_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0100
) (
    input  logic              i_clk,
    input  logic              i_reset,
    gb80_fetch_unit_if.master bus
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    entry_t                q_mem [QUEUE_DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q, count_after;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // An ack only counts while a request is actually on the bus.
    assign push        = (state_q == REQ) && bus.i_mem_ack && !bus.i_redirect;
    assign pop         = (count_q != '0) && bus.i_instr_ready && !bus.i_redirect;
    assign count_after = count_q + CW'(push) - CW'(pop);
    assign pc_inc      = pc_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.i_redirect) begin
                    pc_d = bus.i_redirect_addr;
                end else if (!bus.i_stall && count_q < DEPTH_C) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (bus.i_redirect) begin
                    pc_d    = bus.i_redirect_addr;
                    state_d = bus.i_mem_ack ? IDLE : FLUSH;
                end else if (bus.i_mem_ack) begin
                    pc_d = pc_inc;
                    if (!bus.i_stall && count_after < DEPTH_C) begin
                        addr_d = pc_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                // Stale request stays on the bus until acked; its data is dropped.
                if (bus.i_redirect) begin
                    pc_d = bus.i_redirect_addr;
                end
                if (bus.i_mem_ack) begin
                    if (!bus.i_redirect && !bus.i_stall && count_q < DEPTH_C) begin
                        state_d = REQ;
                        addr_d  = pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (bus.i_redirect) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                q_mem[tail_q] <= '{addr: addr_q, data: bus.i_mem_data};
                tail_q        <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_after;
        end
    end

    assign bus.o_mem_req     = (state_q == REQ) || (state_q == FLUSH);
    assign bus.o_mem_addr    = addr_q;
    assign bus.o_fetch_pc    = pc_q;
    assign bus.o_queue_count = count_q;
    assign bus.o_instr_valid = (count_q != '0);
    assign bus.o_instr_data  = q_mem[head_q].data;
    assign bus.o_instr_addr  = q_mem[head_q].addr;
endmodule

// File: tb/tb_gb80_fetch_unit.sv
// Directed bench for gb80_fetch_unit: reset, streaming, queue full, wait states,
// redirect flush, address wrap and stall, against hand-computed expectations.
module tb_gb80_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;
    int   acc_base = 0;

    gb80_fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .QUEUE_DEPTH(4)) bus ();

    gb80_fetch_unit #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .QUEUE_DEPTH(4), .RESET_VECTOR(16'h0100)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign bus.i_mem_data = mem_byte(bus.o_mem_addr);

    always @(posedge clk) begin
        if (!rst && bus.o_mem_req && bus.i_mem_ack) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks outputs before any clock edge, then releases.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_req",   32'(bus.o_mem_req),     32'h0);
        chk("rst_addr",  32'(bus.o_mem_addr),    32'h0100);
        chk("rst_pc",    32'(bus.o_fetch_pc),    32'h0100);
        chk("rst_valid", 32'(bus.o_instr_valid), 32'h0);
        chk("rst_count", 32'(bus.o_queue_count), 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.i_mem_ack       = 1'b0;
        bus.i_instr_ready   = 1'b0;
        bus.i_redirect      = 1'b0;
        bus.i_redirect_addr = 16'h0000;
        bus.i_stall         = 1'b0;
        #1;
        do_reset();
        chk("rst_idata", 32'(bus.o_instr_data), 32'h0);
        chk("rst_iaddr", 32'(bus.o_instr_addr), 32'h0);

        // Streaming with always-ack memory and a ready decoder
        bus.i_mem_ack     = 1'b1;
        bus.i_instr_ready = 1'b1;
        tick();
        chk("s_req0",  32'(bus.o_mem_req),  32'h1);
        chk("s_addr0", 32'(bus.o_mem_addr), 32'h0100);
        tick();
        chk("s_addr1",  32'(bus.o_mem_addr),    32'h0101);
        chk("s_valid",  32'(bus.o_instr_valid), 32'h1);
        chk("s_iaddr0", 32'(bus.o_instr_addr),  32'h0100);
        chk("s_idata0", 32'(bus.o_instr_data),  32'(mem_byte(16'h0100)));
        tick();
        chk("s_addr2",  32'(bus.o_mem_addr),    32'h0102);
        chk("s_iaddr1", 32'(bus.o_instr_addr),  32'h0101);
        chk("s_count",  32'(bus.o_queue_count), 32'h1);

        // Queue fill with decoder not ready; reset lands mid-request
        bus.i_instr_ready = 1'b0;
        do_reset();
        acc_base = n_acc;
        repeat (8) tick();
        chk("f_nreq",  32'(n_acc - acc_base),   32'd4);
        chk("f_count", 32'(bus.o_queue_count), 32'h4);
        chk("f_req",   32'(bus.o_mem_req),     32'h0);
        chk("f_pc",    32'(bus.o_fetch_pc),    32'h0104);
        chk("f_head",  32'(bus.o_instr_addr),  32'h0100);
        bus.i_instr_ready = 1'b1;
        tick();
        bus.i_instr_ready = 1'b0;
        chk("f_count3", 32'(bus.o_queue_count), 32'h3);
        tick();
        chk("f_req2",  32'(bus.o_mem_req),  32'h1);
        chk("f_addr2", 32'(bus.o_mem_addr), 32'h0104);
        tick();
        chk("f_req3",   32'(bus.o_mem_req),     32'h0);
        chk("f_count4", 32'(bus.o_queue_count), 32'h4);
        repeat (2) tick();
        chk("f_nreq5", 32'(n_acc - acc_base), 32'd5);

        // Wait states: ack held off three cycles
        bus.i_mem_ack = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w_req",  32'(bus.o_mem_req),  32'h1);
            chk("w_addr", 32'(bus.o_mem_addr), 32'h0100);
        end
        chk("w_count0", 32'(bus.o_queue_count), 32'h0);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("w_count1", 32'(bus.o_queue_count), 32'h1);
        chk("w_iaddr",  32'(bus.o_instr_addr),  32'h0100);
        chk("w_addr1",  32'(bus.o_mem_addr),    32'h0101);

        // Redirect to 0038 while 0102 is pending
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("r_addr102", 32'(bus.o_mem_addr),    32'h0102);
        chk("r_count2",  32'(bus.o_queue_count), 32'h2);
        bus.i_redirect      = 1'b1;
        bus.i_redirect_addr = 16'h0038;
        tick();
        bus.i_redirect = 1'b0;
        chk("r_req",    32'(bus.o_mem_req),     32'h1);
        chk("r_hold",   32'(bus.o_mem_addr),    32'h0102);
        chk("r_count",  32'(bus.o_queue_count), 32'h0);
        chk("r_valid",  32'(bus.o_instr_valid), 32'h0);
        chk("r_pc",     32'(bus.o_fetch_pc),    32'h0038);
        tick();
        chk("r_hold2", 32'(bus.o_mem_addr), 32'h0102);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("r_drop",  32'(bus.o_queue_count), 32'h0);
        chk("r_new",   32'(bus.o_mem_addr),    32'h0038);
        chk("r_newrq", 32'(bus.o_mem_req),     32'h1);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        chk("r_iaddr", 32'(bus.o_instr_addr),  32'h0038);
        chk("r_idata", 32'(bus.o_instr_data),  32'(mem_byte(16'h0038)));
        chk("r_cnt1",  32'(bus.o_queue_count), 32'h1);

        // Redirect to FFFE with an ack in the same cycle, then wrap
        bus.i_redirect      = 1'b1;
        bus.i_redirect_addr = 16'hFFFE;
        bus.i_mem_ack       = 1'b1;
        bus.i_instr_ready   = 1'b1;
        tick();
        bus.i_redirect = 1'b0;
        chk("x_req",   32'(bus.o_mem_req),     32'h0);
        chk("x_count", 32'(bus.o_queue_count), 32'h0);
        chk("x_pc",    32'(bus.o_fetch_pc),    32'hFFFE);
        tick();
        chk("x_a0", 32'(bus.o_mem_addr), 32'hFFFE);
        tick();
        chk("x_a1", 32'(bus.o_mem_addr),   32'hFFFF);
        chk("x_h0", 32'(bus.o_instr_addr), 32'hFFFE);
        tick();
        chk("x_a2", 32'(bus.o_mem_addr),   32'h0000);
        chk("x_h1", 32'(bus.o_instr_addr), 32'hFFFF);
        tick();
        chk("x_h2", 32'(bus.o_instr_addr), 32'h0000);
        chk("x_a3", 32'(bus.o_mem_addr),   32'h0001);

        // Stall with a request pending: it completes, no further issue
        bus.i_mem_ack     = 1'b0;
        bus.i_instr_ready = 1'b0;
        bus.i_stall       = 1'b1;
        tick();
        chk("t_req",  32'(bus.o_mem_req),  32'h1);
        chk("t_addr", 32'(bus.o_mem_addr), 32'h0001);
        acc_base = n_acc;
        bus.i_mem_ack = 1'b1;
        tick();
        chk("t_count", 32'(bus.o_queue_count), 32'h2);
        chk("t_idle",  32'(bus.o_mem_req),     32'h0);
        repeat (3) tick();
        chk("t_still", 32'(bus.o_mem_req),    32'h0);
        chk("t_nacc",  32'(n_acc - acc_base), 32'd1);
        chk("t_pc",    32'(bus.o_fetch_pc),   32'h0002);
        bus.i_stall = 1'b0;
        tick();
        chk("t_resume", 32'(bus.o_mem_addr), 32'h0002);
        chk("t_rq",     32'(bus.o_mem_req),  32'h1);

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
